imem_boot_loader: RTL



---
 rtl/imem_boot_loader_if.sv | 24 ++
 rtl/imem_boot_loader.sv | 120 ++++++++++++
 2 files changed

// File: rtl/imem_boot_loader_if.sv
// Byte-stream in / imem write port / CPU boot status bundle for the boot loader.
interface imem_boot_loader_if #(
  parameter int ADDR_W = 6
);
  logic              in_valid;
  logic [7:0]        in_byte;
  logic              in_ready;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [31:0]       wdata;
  logic              cpu_reset;
  logic              done;
  logic              error;

  modport slave (
    input  in_valid, in_byte,
    output in_ready, we, waddr, wdata, cpu_reset, done, error
  );

  modport master (
    output in_valid, in_byte,
    input  in_ready, we, waddr, wdata, cpu_reset, done, error
  );
endinterface

// File: rtl/imem_boot_loader.sv
// Loads a counted little-endian byte stream into imem word by word, then
// releases the core from reset.
module imem_boot_loader #(
  parameter int ADDR_W = 6
) (
  input  logic               clk,
  input  logic               reset,
  imem_boot_loader_if.slave  bus
);
  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [2:0] {S_CNT_LO, S_CNT_HI, S_DATA, S_RUN, S_ERR} state_e;

  state_e            state_q, state_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [1:0]        bidx_q, bidx_d;
  logic [ADDR_W:0]   widx_q, widx_d;
  logic [23:0]       asm_q, asm_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              cpu_reset_q, cpu_reset_d;
  logic              done_q, done_d;
  logic              error_q, error_d;

  logic              in_ready;
  logic              xfer;
  logic [15:0]       n_full;
  logic [ADDR_W:0]   widx_inc;

  assign in_ready = (state_q == S_CNT_LO) || (state_q == S_CNT_HI) || (state_q == S_DATA);
  assign xfer     = bus.in_valid && in_ready;
  assign n_full   = {bus.in_byte, cnt_q[7:0]};
  assign widx_inc = widx_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bidx_d      = bidx_q;
    widx_d      = widx_q;
    asm_d       = asm_q;
    we_d        = 1'b0;
    waddr_d     = waddr_q;
    wdata_d     = wdata_q;
    cpu_reset_d = cpu_reset_q;
    done_d      = done_q;
    error_d     = error_q;
    case (state_q)
      S_CNT_LO: if (xfer) begin
        cnt_d[7:0] = bus.in_byte;
        state_d    = S_CNT_HI;
      end
      S_CNT_HI: if (xfer) begin
        cnt_d = n_full;
        if (n_full == 16'd0 || n_full > 16'(DEPTH)) begin
          state_d = S_ERR;
          error_d = 1'b1;
        end else begin
          state_d = S_DATA;
          widx_d  = '0;
          bidx_d  = '0;
        end
      end
      S_DATA: if (xfer) begin
        // Shift register: after three bytes asm holds {b2,b1,b0}.
        asm_d  = {bus.in_byte, asm_q[23:8]};
        bidx_d = bidx_q + 2'd1;
        if (bidx_q == 2'd3) begin
          we_d    = 1'b1;
          wdata_d = {bus.in_byte, asm_q};
          waddr_d = widx_q[ADDR_W-1:0];
          widx_d  = widx_inc;
          if (16'(widx_inc) == cnt_q) state_d = S_RUN;
        end
      end
      S_RUN: begin
        cpu_reset_d = 1'b0;
        done_d      = 1'b1;
      end
      S_ERR:   error_d = 1'b1;
      default: state_d = S_ERR;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_CNT_LO;
      cnt_q       <= '0;
      bidx_q      <= '0;
      widx_q      <= '0;
      asm_q       <= '0;
      we_q        <= 1'b0;
      waddr_q     <= '0;
      wdata_q     <= '0;
      cpu_reset_q <= 1'b1;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bidx_q      <= bidx_d;
      widx_q      <= widx_d;
      asm_q       <= asm_d;
      we_q        <= we_d;
      waddr_q     <= waddr_d;
      wdata_q     <= wdata_d;
      cpu_reset_q <= cpu_reset_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.we        = we_q;
  assign bus.waddr     = waddr_q;
  assign bus.wdata     = wdata_q;
  assign bus.cpu_reset = cpu_reset_q;
  assign bus.done      = done_q;
  assign bus.error     = error_q;
endmodule
